// File: rtl/data_mem_controller.sv
// data_mem_controller: arbitrates per-thread LSU data requests onto
// NUM_CHANNELS memory channels, each claiming consumers round-robin.
module data_mem_controller #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 1,
   parameter int WRITE_ENABLE  = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]            mem_read_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
   output logic [NUM_CHANNELS-1:0]            mem_write_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
   output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
   input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

   localparam int NC  = NUM_CONSUMERS;
   localparam int NCH = NUM_CHANNELS;
   localparam int AB  = ADDR_BITS;
   localparam int DB  = DATA_BITS;
   localparam int CW  = (NC > 1) ? $clog2(NC) : 1;
   localparam bit WE  = (WRITE_ENABLE != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_WAIT,
      S_WR_WAIT,
      S_RD_RELAY,
      S_WR_RELAY
   } state_t;

   state_t        state_q [NCH];
   state_t        state_d [NCH];
   logic [CW-1:0] cidx_q  [NCH];
   logic [CW-1:0] cidx_d  [NCH];
   logic [CW-1:0] rr_q    [NCH];
   logic [CW-1:0] rr_d    [NCH];
   logic [AB-1:0] raddr_q [NCH];
   logic [AB-1:0] raddr_d [NCH];
   logic [AB-1:0] waddr_q [NCH];
   logic [AB-1:0] waddr_d [NCH];
   logic [DB-1:0] wdata_q [NCH];
   logic [DB-1:0] wdata_d [NCH];
   logic [DB-1:0] rdata_q [NC];
   logic [DB-1:0] rdata_d [NC];

   logic [NCH-1:0] mrv_q, mrv_d;
   logic [NCH-1:0] mwv_q, mwv_d;
   logic [NC-1:0]  claim_q, claim_d;
   logic [NC-1:0]  rrdy_q, rrdy_d;
   logic [NC-1:0]  wrdy_q, wrdy_d;

   logic [AB-1:0] c_raddr [NC];
   logic [AB-1:0] c_waddr [NC];
   logic [DB-1:0] c_wdata [NC];
   logic [NC-1:0] rd_req;
   logic [NC-1:0] wr_req;

   logic [NC-1:0] taken;
   logic          found;
   logic [CW-1:0] pick;
   logic [CW:0]   scan;

   logic [NC-1:0] rd_wait;
   logic [NC-1:0] wr_wait;

   for (genvar i = 0; i < NC; i++) begin : g_cons
      assign c_raddr[i] = consumer_read_address[i*AB +: AB];
      assign c_waddr[i] = consumer_write_address[i*AB +: AB];
      assign c_wdata[i] = consumer_write_data[i*DB +: DB];
      assign consumer_read_data[i*DB +: DB] = rdata_q[i];
   end

   for (genvar h = 0; h < NCH; h++) begin : g_chan
      assign mem_read_address[h*AB +: AB] = raddr_q[h];
      assign mem_write_address[h*AB +: AB] =
         WE ? waddr_q[h] : '0;
      assign mem_write_data[h*DB +: DB] =
         WE ? wdata_q[h] : '0;
   end

   assign rd_req               = consumer_read_valid;
   assign wr_req               = WE ? consumer_write_valid : '0;
   assign consumer_read_ready  = rrdy_q;
   assign consumer_write_ready = WE ? wrdy_q : '0;
   assign mem_read_valid       = mrv_q;
   assign mem_write_valid      = WE ? mwv_q : '0;

   // channel FSMs: lower channels claim first, then wait and relay
   always_comb begin
      state_d = state_q;
      cidx_d  = cidx_q;
      rr_d    = rr_q;
      raddr_d = raddr_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      mrv_d   = mrv_q;
      mwv_d   = mwv_q;
      claim_d = claim_q;
      rrdy_d  = rrdy_q;
      wrdy_d  = wrdy_q;
      taken   = claim_q;
      found   = 1'b0;
      pick    = '0;
      scan    = '0;
      for (int h = 0; h < NCH; h++) begin
         unique case (state_q[h])
            S_IDLE: begin
               found = 1'b0;
               pick  = '0;
               for (int k = 0; k < NC; k++) begin
                  scan = {1'b0, rr_q[h]} + (CW+1)'(k);
                  if (scan >= (CW+1)'(NC))
                     scan = scan - (CW+1)'(NC);
                  if (!found
                      && !taken[scan[CW-1:0]]
                      && (rd_req[scan[CW-1:0]]
                          || wr_req[scan[CW-1:0]])) begin
                     found = 1'b1;
                     pick  = scan[CW-1:0];
                  end
               end
               if (found) begin
                  taken[pick]   = 1'b1;
                  claim_d[pick] = 1'b1;
                  cidx_d[h]     = pick;
                  rr_d[h] = (pick == CW'(NC - 1)) ?
                            '0 : pick + CW'(1);
                  if (rd_req[pick]) begin
                     raddr_d[h] = c_raddr[pick];
                     mrv_d[h]   = 1'b1;
                     state_d[h] = S_RD_WAIT;
                  end else begin
                     waddr_d[h] = c_waddr[pick];
                     wdata_d[h] = c_wdata[pick];
                     mwv_d[h]   = 1'b1;
                     state_d[h] = S_WR_WAIT;
                  end
               end
            end
            S_RD_WAIT: begin
               if (mem_read_ready[h]) begin
                  rdata_d[cidx_q[h]] = mem_read_data[h*DB +: DB];
                  rrdy_d[cidx_q[h]]  = 1'b1;
                  mrv_d[h]           = 1'b0;
                  state_d[h]         = S_RD_RELAY;
               end
            end
            S_WR_WAIT: begin
               if (mem_write_ready[h]) begin
                  wrdy_d[cidx_q[h]] = 1'b1;
                  mwv_d[h]          = 1'b0;
                  state_d[h]        = S_WR_RELAY;
               end
            end
            S_RD_RELAY: begin
               if (!consumer_read_valid[cidx_q[h]]) begin
                  rrdy_d[cidx_q[h]]  = 1'b0;
                  claim_d[cidx_q[h]] = 1'b0;
                  state_d[h]         = S_IDLE;
               end
            end
            S_WR_RELAY: begin
               if (!consumer_write_valid[cidx_q[h]]) begin
                  wrdy_d[cidx_q[h]]  = 1'b0;
                  claim_d[cidx_q[h]] = 1'b0;
                  state_d[h]         = S_IDLE;
               end
            end
            default: state_d[h] = S_IDLE;
         endcase
      end
   end

   // state registers; reset aborts any transaction in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int h = 0; h < NCH; h++) begin
            state_q[h] <= S_IDLE;
            cidx_q[h]  <= '0;
            rr_q[h]    <= '0;
            raddr_q[h] <= '0;
            waddr_q[h] <= '0;
            wdata_q[h] <= '0;
         end
         for (int i = 0; i < NC; i++)
            rdata_q[i] <= '0;
         mrv_q   <= '0;
         mwv_q   <= '0;
         claim_q <= '0;
         rrdy_q  <= '0;
         wrdy_q  <= '0;
      end else begin
         state_q <= state_d;
         cidx_q  <= cidx_d;
         rr_q    <= rr_d;
         raddr_q <= raddr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         mrv_q   <= mrv_d;
         mwv_q   <= mwv_d;
         claim_q <= claim_d;
         rrdy_q  <= rrdy_d;
         wrdy_q  <= wrdy_d;
      end
   end

   // consumers still owed a memory completion
   always_comb begin
      rd_wait = '0;
      wr_wait = '0;
      for (int h = 0; h < NCH; h++) begin
         if (state_q[h] == S_RD_WAIT)
            rd_wait[cidx_q[h]] = 1'b1;
         if (state_q[h] == S_WR_WAIT)
            wr_wait[cidx_q[h]] = 1'b1;
      end
   end

   for (genvar i = 0; i < NC; i++) begin : g_sva
      a_rd_hold: assert property (
         @(posedge clk) disable iff (!reset)
         rd_wait[i] |-> consumer_read_valid[i]);
      a_wr_hold: assert property (
         @(posedge clk) disable iff (!reset)
         wr_wait[i] |-> consumer_write_valid[i]);
   end

endmodule

// File: tb/tb_data_mem_controller.sv
// tb_data_mem_controller: directed checks of arbitration, relay,
// write path, read-only build and asynchronous reset.
`timescale 1ns/1ps
module tb_data_mem_controller;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // single channel, writes enabled
   logic [3:0]  rv, rrdy, wv, wrdy;
   logic [31:0] ra, rdata, wa, wd;
   logic        mrv, mrr, mwv, mwr;
   logic [7:0]  mra, mrd, mwa, mwd;

   // two channels, read-only
   logic [3:0]  b_rv, b_rrdy, b_wv, b_wrdy;
   logic [31:0] b_ra, b_rdata, b_wa, b_wd;
   logic [1:0]  b_mrv, b_mrr, b_mwv, b_mwr;
   logic [15:0] b_mra, b_mrd, b_mwa, b_mwd;

   data_mem_controller #(
      .NUM_CHANNELS(1),
      .WRITE_ENABLE(1)
   ) u1 (
      .clk                   (clk),
      .reset                 (reset),
      .consumer_read_valid   (rv),
      .consumer_read_address (ra),
      .consumer_read_ready   (rrdy),
      .consumer_read_data    (rdata),
      .consumer_write_valid  (wv),
      .consumer_write_address(wa),
      .consumer_write_data   (wd),
      .consumer_write_ready  (wrdy),
      .mem_read_valid        (mrv),
      .mem_read_address      (mra),
      .mem_read_ready        (mrr),
      .mem_read_data         (mrd),
      .mem_write_valid       (mwv),
      .mem_write_address     (mwa),
      .mem_write_data        (mwd),
      .mem_write_ready       (mwr)
   );

   data_mem_controller #(
      .NUM_CHANNELS(2),
      .WRITE_ENABLE(0)
   ) u2 (
      .clk                   (clk),
      .reset                 (reset),
      .consumer_read_valid   (b_rv),
      .consumer_read_address (b_ra),
      .consumer_read_ready   (b_rrdy),
      .consumer_read_data    (b_rdata),
      .consumer_write_valid  (b_wv),
      .consumer_write_address(b_wa),
      .consumer_write_data   (b_wd),
      .consumer_write_ready  (b_wrdy),
      .mem_read_valid        (b_mrv),
      .mem_read_address      (b_mra),
      .mem_read_ready        (b_mrr),
      .mem_read_data         (b_mrd),
      .mem_write_valid       (b_mwv),
      .mem_write_address     (b_mwa),
      .mem_write_data        (b_mwd),
      .mem_write_ready       (b_mwr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rv = '0; ra = '0; wv = '0; wa = '0; wd = '0;
      mrr = 1'b0; mrd = '0; mwr = 1'b0;
      b_rv = '0; b_ra = '0; b_wv = '0; b_wa = '0; b_wd = '0;
      b_mrr = '0; b_mrd = '0; b_mwr = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      tick();
      tick();
      checks++;
      if ({rrdy, wrdy, mrv, mwv} !== 10'h0) begin
         errors++;
         $display("FAIL reset_hs: got %h expected 0",
                  {rrdy, wrdy, mrv, mwv});
      end
      checks++;
      if ({rdata, mra, mwa, mwd} !== 56'h0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 0",
                  {rdata, mra, mwa, mwd});
      end
      checks++;
      if ({b_rrdy, b_wrdy, b_mrv, b_mwv, b_mra} !== 28'h0) begin
         errors++;
         $display("FAIL reset_ro: got %h expected 0",
                  {b_rrdy, b_wrdy, b_mrv, b_mwv, b_mra});
      end
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({rrdy, wrdy, mrv, mwv} !== 10'h0) begin
         errors++;
         $display("FAIL idle_quiet: got %h expected 0",
                  {rrdy, wrdy, mrv, mwv});
      end
   endtask

   task automatic test_single_read();
      ra[23:16] = 8'h10;
      rv[2] = 1'b1;
      tick();
      checks++;
      if (mrv !== 1'b1 || mra !== 8'h10) begin
         errors++;
         $display("FAIL single_req: got v=%b a=%h expected 1/10",
                  mrv, mra);
      end
      tick();
      tick();
      checks++;
      if (mrv !== 1'b1 || mra !== 8'h10 || rrdy !== 4'h0) begin
         errors++;
         $display("FAIL single_hold: got v=%b a=%h r=%b expected 1/10/0",
                  mrv, mra, rrdy);
      end
      mrr = 1'b1;
      mrd = 8'hAB;
      tick();
      mrr = 1'b0;
      mrd = 8'h00;
      checks++;
      if (rrdy !== 4'b0100 || rdata[23:16] !== 8'hAB || mrv !== 1'b0) begin
         errors++;
         $display("FAIL single_resp: got r=%b d=%h v=%b expected 0100/ab/0",
                  rrdy, rdata[23:16], mrv);
      end
      tick();
      checks++;
      if (rrdy !== 4'b0100 || rdata[23:16] !== 8'hAB) begin
         errors++;
         $display("FAIL single_relay: got r=%b d=%h expected 0100/ab",
                  rrdy, rdata[23:16]);
      end
      rv[2] = 1'b0;
      tick();
      checks++;
      if (rrdy !== 4'h0) begin
         errors++;
         $display("FAIL single_clear: got %b expected 0000", rrdy);
      end
   endtask

   task automatic test_fairness();
      int exp;
      do_reset();
      for (int r = 0; r < 2; r++) begin
         if (r == 1) begin
            ra[15:8] = 8'h41;
            rv = 4'b0010;
            tick();
            mrr = 1'b1;
            tick();
            mrr = 1'b0;
            rv = 4'b0000;
            tick();
         end
         for (int i = 0; i < 4; i++)
            ra[i*8 +: 8] = 8'h40 + 8'(i);
         rv = 4'hF;
         for (int i = 0; i < 4; i++) begin
            exp = (2 * r + i) % 4;
            tick();
            checks++;
            if (mrv !== 1'b1 || mra !== 8'h40 + 8'(exp)) begin
               errors++;
               $display("FAIL fair_order: got v=%b a=%h expected 1/%h",
                        mrv, mra, 8'h40 + 8'(exp));
            end
            mrd = 8'hC0 + 8'(exp);
            mrr = 1'b1;
            tick();
            mrr = 1'b0;
            checks++;
            if (rrdy !== 4'(1 << exp)
                || rdata[exp*8 +: 8] !== 8'hC0 + 8'(exp)) begin
               errors++;
               $display("FAIL fair_resp: got r=%b d=%h expected %b/%h",
                        rrdy, rdata[exp*8 +: 8], 4'(1 << exp),
                        8'hC0 + 8'(exp));
            end
            rv[exp] = 1'b0;
            tick();
            checks++;
            if (rrdy !== 4'h0) begin
               errors++;
               $display("FAIL fair_clear: got %b expected 0000", rrdy);
            end
         end
      end
   endtask

   task automatic test_two_channels();
      b_ra[7:0] = 8'h60;
      b_ra[15:8] = 8'h61;
      b_rv = 4'b0011;
      tick();
      checks++;
      if (b_mrv !== 2'b11 || b_mra !== 16'h6160) begin
         errors++;
         $display("FAIL two_claim: got v=%b a=%h expected 11/6160",
                  b_mrv, b_mra);
      end
      b_mrd = 16'hE1E0;
      b_mrr = 2'b11;
      tick();
      b_mrr = 2'b00;
      checks++;
      if (b_rrdy !== 4'b0011 || b_rdata[15:0] !== 16'hE1E0
          || b_mrv !== 2'b00) begin
         errors++;
         $display("FAIL two_resp: got r=%b d=%h v=%b expected 0011/e1e0/00",
                  b_rrdy, b_rdata[15:0], b_mrv);
      end
      b_rv = 4'b0000;
      tick();
      checks++;
      if (b_rrdy !== 4'h0 || b_mrv !== 2'b00) begin
         errors++;
         $display("FAIL two_clear: got r=%b v=%b expected 0000/00",
                  b_rrdy, b_mrv);
      end
   endtask

   task automatic test_write();
      wa[31:24] = 8'h22;
      wd[31:24] = 8'h5C;
      wv[3] = 1'b1;
      tick();
      checks++;
      if (mwv !== 1'b1 || mwa !== 8'h22 || mwd !== 8'h5C
          || mrv !== 1'b0) begin
         errors++;
         $display("FAIL write_req: got v=%b a=%h d=%h rv=%b expected 1/22/5c/0",
                  mwv, mwa, mwd, mrv);
      end
      tick();
      checks++;
      if (mwv !== 1'b1 || mwa !== 8'h22 || wrdy !== 4'h0) begin
         errors++;
         $display("FAIL write_hold: got v=%b a=%h r=%b expected 1/22/0",
                  mwv, mwa, wrdy);
      end
      mwr = 1'b1;
      tick();
      mwr = 1'b0;
      checks++;
      if (wrdy !== 4'b1000 || mwv !== 1'b0) begin
         errors++;
         $display("FAIL write_resp: got r=%b v=%b expected 1000/0",
                  wrdy, mwv);
      end
      wv[3] = 1'b0;
      tick();
      checks++;
      if (wrdy !== 4'h0) begin
         errors++;
         $display("FAIL write_clear: got %b expected 0000", wrdy);
      end
   endtask

   task automatic test_write_disabled();
      b_wa[31:24] = 8'h22;
      b_wd[31:24] = 8'h5C;
      b_wv[3] = 1'b1;
      b_mwr = 2'b11;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (b_mwv !== 2'b00 || b_wrdy !== 4'h0 || b_mrv !== 2'b00
             || b_mwa !== 16'h0 || b_mwd !== 16'h0) begin
            errors++;
            $display("FAIL ro_write: got v=%b r=%b a=%h d=%h expected all 0",
                     b_mwv, b_wrdy, b_mwa, b_mwd);
         end
      end
      b_wv = 4'b0000;
      b_mwr = 2'b00;
   endtask

   task automatic test_reset_mid();
      ra[7:0] = 8'h33;
      rv[0] = 1'b1;
      tick();
      checks++;
      if (mrv !== 1'b1 || mra !== 8'h33) begin
         errors++;
         $display("FAIL mid_req: got v=%b a=%h expected 1/33", mrv, mra);
      end
      #2;
      reset = 1'b0;
      rv = 4'b0000;
      #1;
      checks++;
      if (mrv !== 1'b0 || mra !== 8'h00 || rrdy !== 4'h0
          || rdata !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset: got v=%b a=%h r=%b d=%h expected 0",
                  mrv, mra, rrdy, rdata);
      end
      tick();
      reset = 1'b1;
      ra[7:0] = 8'h34;
      rv[0] = 1'b1;
      tick();
      checks++;
      if (mrv !== 1'b1 || mra !== 8'h34) begin
         errors++;
         $display("FAIL mid_fresh: got v=%b a=%h expected 1/34", mrv, mra);
      end
      mrd = 8'h77;
      mrr = 1'b1;
      tick();
      mrr = 1'b0;
      checks++;
      if (rrdy !== 4'b0001 || rdata[7:0] !== 8'h77) begin
         errors++;
         $display("FAIL mid_resp: got r=%b d=%h expected 0001/77",
                  rrdy, rdata[7:0]);
      end
      rv[0] = 1'b0;
      tick();
      checks++;
      if (rrdy !== 4'h0) begin
         errors++;
         $display("FAIL mid_clear: got %b expected 0000", rrdy);
      end
   endtask

   task automatic test_read_write();
      ra[15:8] = 8'h50;
      wa[15:8] = 8'h51;
      wd[15:8] = 8'h99;
      rv[1] = 1'b1;
      wv[1] = 1'b1;
      tick();
      checks++;
      if (mrv !== 1'b1 || mra !== 8'h50 || mwv !== 1'b0) begin
         errors++;
         $display("FAIL rw_first: got rv=%b a=%h wv=%b expected 1/50/0",
                  mrv, mra, mwv);
      end
      mrd = 8'h3C;
      mrr = 1'b1;
      tick();
      checks++;
      if (rrdy !== 4'b0010 || rdata[15:8] !== 8'h3C || mrv !== 1'b0) begin
         errors++;
         $display("FAIL rw_resp: got r=%b d=%h v=%b expected 0010/3c/0",
                  rrdy, rdata[15:8], mrv);
      end
      tick();
      tick();
      mrr = 1'b0;
      checks++;
      if (mrv !== 1'b0 || mwv !== 1'b0 || rrdy !== 4'b0010
          || wrdy !== 4'h0) begin
         errors++;
         $display("FAIL rw_once: got rv=%b wv=%b r=%b w=%b expected 0/0/0010/0",
                  mrv, mwv, rrdy, wrdy);
      end
      rv[1] = 1'b0;
      tick();
      checks++;
      if (rrdy !== 4'h0 || mwv !== 1'b0) begin
         errors++;
         $display("FAIL rw_release: got r=%b wv=%b expected 0000/0",
                  rrdy, mwv);
      end
      tick();
      checks++;
      if (mwv !== 1'b1 || mwa !== 8'h51 || mwd !== 8'h99
          || mrv !== 1'b0) begin
         errors++;
         $display("FAIL rw_second: got v=%b a=%h d=%h rv=%b expected 1/51/99/0",
                  mwv, mwa, mwd, mrv);
      end
      mwr = 1'b1;
      tick();
      mwr = 1'b0;
      checks++;
      if (wrdy !== 4'b0010 || mwv !== 1'b0) begin
         errors++;
         $display("FAIL rw_wresp: got r=%b v=%b expected 0010/0", wrdy, mwv);
      end
      wv[1] = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if ({mrv, mwv, rrdy, wrdy} !== 10'h0) begin
         errors++;
         $display("FAIL rw_quiet: got %h expected 0",
                  {mrv, mwv, rrdy, wrdy});
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_fairness();
      test_two_channels();
      test_write();
      test_write_disabled();
      test_reset_mid();
      test_read_write();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
